// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch-address sequencer: PC/nPC pair, branch/jump redirect, delay-slot or squash mode
module pc_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter bit          DELAY_SLOT = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_valid,
    input  logic        ch_out,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] pc,
    output logic [31:0] npc,
    output logic [31:0] link_addr,
    output logic        if_id_reset,
    output logic        addr_err,
    output logic        slot_err
);

    typedef enum logic {
        SEQ    = 1'b0,
        SHADOW = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        req;
    logic        take;
    logic [31:0] tgt_raw;
    logic [31:0] tgt;
    logic [31:0] pc_next;
    logic [31:0] npc_next;
    logic [31:0] link_next;
    logic        addr_err_next;
    logic        slot_err_next;

    // Jump wins over a simultaneous conditional branch; low bits are dropped so fetch stays aligned.
    assign req     = jump | (branch_valid & ch_out);
    assign tgt_raw = jump ? jump_target : branch_target;
    assign tgt     = {tgt_raw[31:2], 2'b00};
    assign take    = req & ~stall & (state == SEQ);

    always_comb begin
        state_next    = state;
        pc_next       = pc;
        npc_next      = npc;
        link_next     = link_addr;
        addr_err_next = 1'b0;
        slot_err_next = 1'b0;

        if (take) begin
            state_next    = SHADOW;
            addr_err_next = |tgt_raw[1:0];
            if (DELAY_SLOT) begin
                pc_next   = npc;
                npc_next  = tgt;
                link_next = pc + 32'd4;
            end else begin
                pc_next   = tgt;
                npc_next  = tgt + 32'd4;
                link_next = pc;
            end
        end else if (!stall) begin
            // The shadow cycle never redirects; a request arriving there is flagged, not honoured.
            state_next    = SEQ;
            slot_err_next = (state == SHADOW) & req;
            pc_next       = npc;
            npc_next      = npc + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SEQ;
            pc        <= RESET_PC;
            npc       <= RESET_PC + 32'd4;
            link_addr <= 32'h0000_0000;
            addr_err  <= 1'b0;
            slot_err  <= 1'b0;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            npc       <= npc_next;
            link_addr <= link_next;
            addr_err  <= addr_err_next;
            slot_err  <= slot_err_next;
        end
    end

    assign if_id_reset = (state == SHADOW) & ~DELAY_SLOT;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer in both delay-slot and squash modes
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        branch_valid;
    logic        ch_out;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;

    logic [31:0] pc1, npc1, link1, pc0, npc0, link0;
    logic        ifr1, ae1, se1, ifr0, ae0, se0;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] npc;
        logic [31:0] link;
        logic        ifr;
        logic        ae;
        logic        se;
    } exp_t;

    exp_t q1[$];
    exp_t q0[$];

    logic [31:0] m_pc[2];
    logic [31:0] m_npc[2];
    logic [31:0] m_link[2];
    logic        m_sh[2];
    logic        m_ae[2];
    logic        m_se[2];

    pc_sequencer #(.RESET_PC(32'h400), .DELAY_SLOT(1'b1)) u_ds1 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .branch_valid(branch_valid),
        .ch_out(ch_out), .branch_target(branch_target), .jump(jump),
        .jump_target(jump_target), .pc(pc1), .npc(npc1), .link_addr(link1),
        .if_id_reset(ifr1), .addr_err(ae1), .slot_err(se1)
    );

    pc_sequencer #(.RESET_PC(32'h400), .DELAY_SLOT(1'b0)) u_ds0 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .branch_valid(branch_valid),
        .ch_out(ch_out), .branch_target(branch_target), .jump(jump),
        .jump_target(jump_target), .pc(pc0), .npc(npc0), .link_addr(link0),
        .if_id_reset(ifr0), .addr_err(ae0), .slot_err(se0)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            m_pc[d]   = 32'h400;
            m_npc[d]  = 32'h404;
            m_link[d] = 32'h0;
            m_sh[d]   = 1'b0;
            m_ae[d]   = 1'b0;
            m_se[d]   = 1'b0;
        end
    endfunction

    function automatic void model_edge(int d);
        logic        r;
        logic [31:0] raw;
        logic [31:0] t;
        logic [31:0] old_pc;
        logic [31:0] old_npc;
        r       = jump | (branch_valid & ch_out);
        raw     = jump ? jump_target : branch_target;
        t       = raw & 32'hFFFF_FFFC;
        old_pc  = m_pc[d];
        old_npc = m_npc[d];
        m_ae[d] = 1'b0;
        m_se[d] = 1'b0;
        if (stall) return;
        if (!m_sh[d] && r) begin
            if (d == 1) begin
                m_pc[d]   = old_npc;
                m_npc[d]  = t;
                m_link[d] = old_pc + 32'd4;
            end else begin
                m_pc[d]   = t;
                m_npc[d]  = t + 32'd4;
                m_link[d] = old_pc;
            end
            m_ae[d] = (raw % 4) != 0;
            m_sh[d] = 1'b1;
        end else begin
            m_se[d]  = m_sh[d] & r;
            m_pc[d]  = old_npc;
            m_npc[d] = old_npc + 32'd4;
            m_sh[d]  = 1'b0;
        end
    endfunction

    function automatic exp_t model_out(int d);
        exp_t e;
        e.pc   = m_pc[d];
        e.npc  = m_npc[d];
        e.link = m_link[d];
        e.ifr  = m_sh[d] && (d == 0);
        e.ae   = m_ae[d];
        e.se   = m_se[d];
        return e;
    endfunction

    task automatic set_in(input logic s, input logic bv, input logic ch, input logic [31:0] bt,
                          input logic j, input logic [31:0] jt);
        stall         = s;
        branch_valid  = bv;
        ch_out        = ch;
        branch_target = bt;
        jump          = j;
        jump_target   = jt;
    endtask

    task automatic step();
        exp_t e;
        model_edge(1);
        q1.push_back(model_out(1));
        model_edge(0);
        q0.push_back(model_out(0));
        @(posedge clk);
        @(negedge clk);
        e = q1.pop_front();
        check_eq("ds1_pc", pc1, e.pc);
        check_eq("ds1_npc", npc1, e.npc);
        check_eq("ds1_link", link1, e.link);
        check_eq("ds1_flags", {29'b0, ifr1, ae1, se1}, {29'b0, e.ifr, e.ae, e.se});
        e = q0.pop_front();
        check_eq("ds0_pc", pc0, e.pc);
        check_eq("ds0_npc", npc0, e.npc);
        check_eq("ds0_link", link0, e.link);
        check_eq("ds0_flags", {29'b0, ifr0, ae0, se0}, {29'b0, e.ifr, e.ae, e.se});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
            step();
        end
    endtask

    initial begin
        logic [31:0] rt;
        rst_n = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        model_reset();
        repeat (2) @(negedge clk);
        check_eq("rst_pc", pc1, 32'h400);
        check_eq("rst_npc", npc1, 32'h404);
        check_eq("rst_link", link0, 32'h0);
        check_eq("rst_flags", {29'b0, ifr0, ae0, se0}, 32'h0);
        rst_n = 1'b1;

        idle(4);
        check_eq("seq_pc4", pc1, 32'h410);

        set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h100);
        step();
        check_eq("ds0_jump_pc", pc0, 32'h100);
        check_eq("ds0_jump_link", link0, 32'h410);
        check_eq("ds0_jump_ifr", {31'b0, ifr0}, 32'h1);
        check_eq("ds1_jump_npc", npc1, 32'h100);
        idle(1);
        check_eq("ds0_ifr_drop", {31'b0, ifr0}, 32'h0);

        set_in(1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0);
        step();
        check_eq("ds1_br_pc", pc1, 32'h104);
        check_eq("ds1_br_npc", npc1, 32'h200);
        check_eq("ds1_br_link", link1, 32'h104);
        set_in(1'b0, 1'b1, 1'b1, 32'h500, 1'b0, 32'h0);
        step();
        check_eq("ds1_slot_pc", pc1, 32'h200);
        check_eq("ds1_slot_err", {31'b0, se1}, 32'h1);
        idle(1);
        check_eq("slot_err_pulse", {30'b0, se1, se0}, 32'h0);

        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h300);
            step();
        end
        set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h300);
        step();
        check_eq("ds0_stall_take_pc", pc0, 32'h300);
        for (int i = 0; i < 2; i++) begin
            set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
            step();
        end
        check_eq("ds0_ifr_held", {31'b0, ifr0}, 32'h1);
        idle(1);

        set_in(1'b0, 1'b1, 1'b1, 32'h203, 1'b0, 32'h0);
        step();
        check_eq("ds0_mis_pc", pc0, 32'h200);
        check_eq("mis_addr_err", {30'b0, ae1, ae0}, 32'h3);
        idle(1);

        set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFF8);
        step();
        idle(3);

        for (int i = 0; i < 60; i++) begin
            rt = $urandom();
            if ($urandom_range(3) != 0) rt[1:0] = 2'b00;
            set_in($urandom_range(3) == 0, 1'($urandom_range(1)), 1'($urandom_range(1)), rt,
                   $urandom_range(4) == 0, rt ^ 32'h0000_1000);
            step();
        end

        idle(1);
        set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h700);
        step();
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_ifr", {31'b0, ifr0}, 32'h0);
        check_eq("async_rst_pc", pc0, 32'h400);
        check_eq("async_rst_npc", npc1, 32'h404);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
